// File: rtl/keccak_pkg.sv
// Shared types and constants for the SHAKE/Keccak pipeline controllers.
package keccak_pkg;

    localparam int KECCAK_NUM_ROUNDS = 24;

    typedef enum logic [1:0] {
        CLEAR,
        ABSORB_WAIT,
        PERMUTE,
        SQUEEZE
    } permute_ctrl_state_t;

endpackage

// File: rtl/permute_control.sv
// Sequencing FSM for permute_datapath: absorbs rate blocks, runs the Keccak-f
// rounds and hands squeeze blocks to the output stage under backpressure.
module permute_control
    import keccak_pkg::*;
#(
    parameter int NUM_ROUNDS = KECCAK_NUM_ROUNDS
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic in_last,
    output logic in_ready,
    input  logic out_ready,
    output logic out_valid,
    output logic out_last,
    input  logic round_done,
    input  logic last_output_block,
    output logic dp_clear,
    output logic copy_control_regs_en,
    output logic absorb_enable,
    output logic round_en,
    output logic round_count_load,
    output logic output_size_count_en,
    output logic busy
);

    // Round 0 runs in the accept cycle, so a permutation needs at least one
    // further PERMUTE cycle to reach round_done.
    if (NUM_ROUNDS < 2) begin : g_bad_num_rounds
        $error("permute_control: NUM_ROUNDS must be at least 2");
    end

    permute_ctrl_state_t state;
    permute_ctrl_state_t state_nxt;
    logic                first_blk;
    logic                last_in;
    logic                accept;

    assign accept = (state == ABSORB_WAIT) && in_valid;

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of process ordering in simulation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= CLEAR;
            first_blk <= 1'b1;
            last_in   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) begin
                first_blk <= 1'b1;
            end else if (accept) begin
                first_blk <= 1'b0;
            end
            if (accept) begin
                last_in <= in_last;
            end
        end
    end

    // NOTE: every output and the next state get a default before the case so
    // no path through this block can infer a latch.
    always_comb begin
        state_nxt            = state;
        in_ready             = 1'b0;
        out_valid            = 1'b0;
        out_last             = 1'b0;
        dp_clear             = 1'b0;
        copy_control_regs_en = 1'b0;
        absorb_enable        = 1'b0;
        round_en             = 1'b0;
        round_count_load     = 1'b0;
        output_size_count_en = 1'b0;
        busy                 = 1'b1;

        unique case (state)
            CLEAR: begin
                dp_clear         = 1'b1;
                round_count_load = 1'b1;
                state_nxt        = ABSORB_WAIT;
            end
            ABSORB_WAIT: begin
                in_ready = 1'b1;
                busy     = !first_blk;
                if (in_valid) begin
                    absorb_enable        = 1'b1;
                    round_en             = 1'b1;
                    copy_control_regs_en = first_blk;
                    state_nxt            = PERMUTE;
                end else begin
                    round_count_load = 1'b1;
                end
            end
            PERMUTE: begin
                round_en = 1'b1;
                if (round_done) begin
                    round_count_load = 1'b1;
                    state_nxt        = last_in ? SQUEEZE : ABSORB_WAIT;
                end
            end
            SQUEEZE: begin
                out_valid        = 1'b1;
                out_last         = last_output_block;
                round_count_load = 1'b1;
                if (out_ready) begin
                    output_size_count_en = 1'b1;
                    state_nxt            = last_output_block ? CLEAR : PERMUTE;
                end
            end
            default: begin
                round_count_load = 1'b1;
                state_nxt        = CLEAR;
            end
        endcase
    end

endmodule
